// File: rtl/uart_rx_frame_ctrl.sv
// UART frame receiver: finds SYNC_BYTE, collects LEN payload bytes plus an XOR checksum,
// and forwards the payload over a valid/ready stream only after the checksum matches.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       pkt_valid,
    output logic [7:0] pkt_data,
    output logic       pkt_last,
    input  logic       pkt_ready,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TMO     = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_PAYLOAD,
        GET_CHK,
        DRAIN
    } state_t;

    state_t           state;
    logic [7:0]       mem [0:DEPTH-1];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_next;
    logic [IDX_W-1:0] last_idx;
    logic [7:0]       chk;
    logic [CNT_W-1:0] tmo_cnt;
    logic             in_frame;
    logic             tmo_hit;
    logic             handshake;

    assign in_frame  = (state == GET_LEN) || (state == GET_PAYLOAD) || (state == GET_CHK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit   = in_frame && !rx_valid && (tmo_cnt == TMO_LAST);
    assign handshake = pkt_valid && pkt_ready;
    assign rd_next   = rd_idx + 1'b1;
    assign pkt_done  = handshake && pkt_last;

    // Payload buffer carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rx_valid && (state == GET_PAYLOAD)) begin
            mem[wr_idx] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            last_idx  <= '0;
            chk       <= '0;
            tmo_cnt   <= '0;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            pkt_last  <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= ERR_OVERRUN;
        end else begin
            pkt_err <= 1'b0;

            if (rx_valid || !in_frame || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state <= GET_LEN;
                    end
                end
                GET_LEN: begin
                    if (rx_valid) begin
                        if ((rx_data != 8'd0) && (rx_data <= MAX_LEN_B)) begin
                            last_idx <= IDX_W'(rx_data - 8'd1);
                            chk      <= rx_data;
                            wr_idx   <= '0;
                            state    <= GET_PAYLOAD;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= ERR_LEN;
                            state    <= IDLE;
                        end
                    end else if (tmo_hit) begin
                        pkt_err  <= 1'b1;
                        err_code <= ERR_TMO;
                        state    <= IDLE;
                    end
                end
                GET_PAYLOAD: begin
                    if (rx_valid) begin
                        chk <= chk ^ rx_data;
                        if (wr_idx == last_idx) begin
                            state <= GET_CHK;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        pkt_err  <= 1'b1;
                        err_code <= ERR_TMO;
                        state    <= IDLE;
                    end
                end
                GET_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk) begin
                            rd_idx    <= '0;
                            pkt_valid <= 1'b1;
                            pkt_data  <= mem[{IDX_W{1'b0}}];
                            pkt_last  <= (last_idx == '0);
                            state     <= DRAIN;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= ERR_CHK;
                            state    <= IDLE;
                        end
                    end else if (tmo_hit) begin
                        pkt_err  <= 1'b1;
                        err_code <= ERR_TMO;
                        state    <= IDLE;
                    end
                end
                DRAIN: begin
                    if (rx_valid) begin
                        pkt_err  <= 1'b1;
                        err_code <= ERR_OVERRUN;
                    end
                    if (handshake) begin
                        if (pkt_last) begin
                            pkt_valid <= 1'b0;
                            pkt_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            rd_idx   <= rd_next;
                            pkt_data <= mem[rd_next];
                            pkt_last <= (rd_next == last_idx);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frame scenarios plus randomized frames checked
// against a byte-stream frame decoder model.
module tb_uart_rx_frame_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         MAXL = 16;
    localparam int         TMO  = 40;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       rx_valid  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       pkt_ready = 1'b1;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       pkt_last;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;

    int   vectors     = 0;
    int   miscompares = 0;
    int   ready_mode  = 0;   // 0 fixed, 1 random, 2 toggle
    logic ready_fixed = 1'b1;

    // Written only by the monitor
    logic [7:0] act_data [$];
    logic       act_last [$];
    logic [1:0] act_err  [$];
    int   done_cnt   = 0;
    int   stall_viol = 0;
    int   both_viol  = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE      (SYNC),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data),
        .pkt_last  (pkt_last),
        .pkt_ready (pkt_ready),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1)      pkt_ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 2) pkt_ready = ~pkt_ready;
        else                      pkt_ready = ready_fixed;
    end

    // Mid-cycle monitor: records handshakes, done pulses, errors and stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && (!pkt_valid || pkt_data !== prev_data || pkt_last !== prev_last))
                stall_viol++;
            if (pkt_valid && pkt_ready) begin
                act_data.push_back(pkt_data);
                act_last.push_back(pkt_last);
            end
            if (pkt_done) done_cnt++;
            if (pkt_err) act_err.push_back(err_code);
            if (pkt_err && pkt_done && err_code != 2'b00) both_viol++;
            prev_stall = pkt_valid && !pkt_ready;
            prev_data  = pkt_data;
            prev_last  = pkt_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pkt_valid && n < 1000) begin
            tick();
            n++;
        end
        vectors++;
        if (pkt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_timeout: pkt_valid=%b still high after %0d cycles, want 0", pkt_valid, n);
        end
    endtask

    // Reference decoder over a byte stream, assuming no overlap with drains.
    task automatic model(input logic [7:0] s[$], output logic [7:0] d[$],
                         output logic l[$], output logic [1:0] e[$]);
        int i = 0;
        int len;
        logic [7:0] x;
        d.delete(); l.delete(); e.delete();
        while (i < s.size()) begin
            if (s[i] != SYNC) begin
                i++;
            end else if (i + 1 >= s.size()) begin
                break;
            end else begin
                len = int'(s[i+1]);
                if (len == 0 || len > MAXL) begin
                    e.push_back(2'b01);
                    i += 2;
                end else if (i + 2 + len >= s.size()) begin
                    break;
                end else begin
                    x = 8'(len);
                    for (int j = 0; j < len; j++) x = x ^ s[i+2+j];
                    if (s[i+2+len] == x) begin
                        for (int j = 0; j < len; j++) begin
                            d.push_back(s[i+2+j]);
                            l.push_back(j == len - 1);
                        end
                    end else begin
                        e.push_back(2'b10);
                    end
                    i += 3 + len;
                end
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({pkt_valid, pkt_last, pkt_data, pkt_done, pkt_err, err_code} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_async: got v=%b l=%b d=%h done=%b err=%b code=%b want all 0",
                     pkt_valid, pkt_last, pkt_data, pkt_done, pkt_err, err_code);
        end
        tick(); tick();
        vectors++;
        if ({pkt_valid, pkt_last, pkt_data, pkt_done, pkt_err, err_code} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_held: got v=%b l=%b d=%h done=%b err=%b code=%b want all 0",
                     pkt_valid, pkt_last, pkt_data, pkt_done, pkt_err, err_code);
        end
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        ready_mode = 0; ready_fixed = 1'b1;
        tick();
        send_byte(SYNC); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        vectors++;
        if (pkt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL good_early: pkt_valid=%b before CHK, want 0", pkt_valid);
        end
        send_byte(8'h03);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({pkt_valid, pkt_data, pkt_last, pkt_done, pkt_err} !== {1'b1, exp_d[k], k == 2, k == 2, 1'b0}) begin
                miscompares++;
                $display("FAIL good_beat%0d: got v=%b d=%h l=%b done=%b err=%b want v=1 d=%h l=%0d done=%0d err=0",
                         k, pkt_valid, pkt_data, pkt_last, pkt_done, pkt_err, exp_d[k], k == 2, k == 2);
            end
            tick();
        end
        vectors++;
        if (pkt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL good_end: pkt_valid=%b after last, want 0", pkt_valid);
        end
    endtask

    task automatic test_bad_chk();
        int d0;
        send_byte(SYNC); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
        vectors++;
        if ({pkt_err, err_code, pkt_valid} !== {1'b1, 2'b10, 1'b0}) begin
            miscompares++;
            $display("FAIL badchk_err: got err=%b code=%b v=%b want err=1 code=10 v=0", pkt_err, err_code, pkt_valid);
        end
        d0 = act_data.size();
        tick(); tick();
        send_byte(SYNC); send_byte(8'h01); send_byte(8'h7E);
        vectors++;
        if (act_data.size() != d0) begin
            miscompares++;
            $display("FAIL badchk_leak: %0d bytes delivered from bad frame, want 0", act_data.size() - d0);
        end
        send_byte(8'h7F);
        vectors++;
        if ({pkt_valid, pkt_data, pkt_last} !== {1'b1, 8'h7E, 1'b1}) begin
            miscompares++;
            $display("FAIL badchk_next: got v=%b d=%h l=%b want v=1 d=7e l=1", pkt_valid, pkt_data, pkt_last);
        end
        wait_idle();
    endtask

    task automatic test_bad_len();
        logic [7:0] lens [2] = '{8'h00, 8'h11};
        for (int k = 0; k < 2; k++) begin
            send_byte(SYNC); send_byte(lens[k]);
            vectors++;
            if ({pkt_err, err_code} !== {1'b1, 2'b01}) begin
                miscompares++;
                $display("FAIL badlen_%h: got err=%b code=%b want err=1 code=01", lens[k], pkt_err, err_code);
            end
            tick();
            vectors++;
            if (pkt_err !== 1'b0) begin
                miscompares++;
                $display("FAIL badlen_pulse_%h: pkt_err=%b second cycle, want 0", lens[k], pkt_err);
            end
        end
        send_byte(SYNC); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
        vectors++;
        if ({pkt_valid, pkt_data, pkt_last} !== {1'b1, 8'h42, 1'b1}) begin
            miscompares++;
            $display("FAIL badlen_idle: got v=%b d=%h l=%b want v=1 d=42 l=1", pkt_valid, pkt_data, pkt_last);
        end
        wait_idle();
    endtask

    task automatic test_timeout();
        int k = 0;
        int e0;
        send_byte(SYNC); send_byte(8'h02); send_byte(8'h10);
        do begin
            tick();
            k++;
        end while (!pkt_err && k < 3 * TMO);
        vectors++;
        if (k != TMO || err_code !== 2'b11) begin
            miscompares++;
            $display("FAIL timeout: err after %0d cycles code=%b, want %0d cycles code=11", k, err_code, TMO);
        end
        // A byte landing exactly on the expiry cycle must be kept
        tick();
        e0 = act_err.size();
        send_byte(SYNC); send_byte(8'h02);
        repeat (TMO - 1) tick();
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h75);
        vectors++;
        if ({pkt_valid, pkt_data} !== {1'b1, 8'h33} || act_err.size() != e0) begin
            miscompares++;
            $display("FAIL timeout_prio: got v=%b d=%h new_errs=%0d want v=1 d=33 new_errs=0",
                     pkt_valid, pkt_data, act_err.size() - e0);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back_overrun();
        int d0 = act_data.size();
        int e0 = act_err.size();
        int n0 = done_cnt;
        int s0 = stall_viol;
        ready_mode = 2;
        send_byte(SYNC); send_byte(8'h02); send_byte(SYNC); send_byte(8'hB6); send_byte(8'h11);
        send_byte(8'h5C);
        wait_idle();
        tick(); tick();
        ready_mode = 0;
        vectors++;
        if (act_data.size() - d0 != 2) begin
            miscompares++;
            $display("FAIL ovr_count: delivered %0d bytes, want 2", act_data.size() - d0);
        end else begin
            vectors++;
            if ({act_data[d0], act_last[d0], act_data[d0+1], act_last[d0+1]} !== {SYNC, 1'b0, 8'hB6, 1'b1}) begin
                miscompares++;
                $display("FAIL ovr_data: got %h/%b %h/%b want a5/0 b6/1",
                         act_data[d0], act_last[d0], act_data[d0+1], act_last[d0+1]);
            end
        end
        vectors++;
        if (act_err.size() - e0 != 1 || (act_err.size() > e0 && act_err[e0] !== 2'b00)) begin
            miscompares++;
            $display("FAIL ovr_err: got %0d errors (first code %b) want 1 error code 00",
                     act_err.size() - e0, act_err.size() > e0 ? act_err[e0] : 2'bxx);
        end
        vectors++;
        if (done_cnt - n0 != 1 || stall_viol != s0) begin
            miscompares++;
            $display("FAIL ovr_done_stall: done=%0d stall_viol=%0d want done=1 stall_viol=0",
                     done_cnt - n0, stall_viol - s0);
        end
    endtask

    task automatic test_reset_mid_drain();
        int e0, n0;
        ready_mode = 0; ready_fixed = 1'b0;
        tick();
        send_byte(SYNC); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h01);
        tick();
        vectors++;
        if ({pkt_valid, pkt_data} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL rstdrain_pre: got v=%b d=%h want v=1 d=01", pkt_valid, pkt_data);
        end
        e0 = act_err.size();
        n0 = done_cnt;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pkt_valid, pkt_last, pkt_data, pkt_done, pkt_err, err_code} !== 13'd0) begin
            miscompares++;
            $display("FAIL rstdrain_out: got v=%b l=%b d=%h done=%b err=%b code=%b want all 0",
                     pkt_valid, pkt_last, pkt_data, pkt_done, pkt_err, err_code);
        end
        tick(); tick();
        rst_n = 1'b1;
        ready_fixed = 1'b1;
        tick(); tick();
        send_byte(SYNC); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
        vectors++;
        if ({pkt_valid, pkt_data, pkt_last} !== {1'b1, 8'h42, 1'b1}) begin
            miscompares++;
            $display("FAIL rstdrain_next: got v=%b d=%h l=%b want v=1 d=42 l=1", pkt_valid, pkt_data, pkt_last);
        end
        wait_idle();
        vectors++;
        if (done_cnt - n0 != 1 || act_err.size() != e0) begin
            miscompares++;
            $display("FAIL rstdrain_pulses: done=%0d errs=%0d want done=1 errs=0", done_cnt - n0, act_err.size() - e0);
        end
    endtask

    task automatic test_random(input int nframes);
        logic [7:0] stream [$];
        logic [7:0] f [$];
        logic [7:0] ed [$];
        logic       el [$];
        logic [1:0] ee [$];
        logic [7:0] b, x;
        int kind, len, ndone;
        int d0 = act_data.size();
        int e0 = act_err.size();
        int n0 = done_cnt;
        ready_mode = 1;
        for (int k = 0; k < nframes; k++) begin
            f.delete();
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                f.push_back(b);
            end
            kind = $urandom_range(0, 9);
            f.push_back(SYNC);
            if (kind < 2) begin
                f.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
            end else begin
                len = $urandom_range(1, MAXL);
                x = 8'(len);
                f.push_back(8'(len));
                for (int j = 0; j < len; j++) begin
                    b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
                    x = x ^ b;
                    f.push_back(b);
                end
                if (kind < 4) x = x ^ 8'(1 << $urandom_range(0, 7));
                f.push_back(x);
            end
            foreach (f[j]) begin
                repeat ($urandom_range(0, 4)) tick();
                send_byte(f[j]);
                stream.push_back(f[j]);
            end
            wait_idle();
            tick(); tick();
        end
        ready_mode = 0;
        model(stream, ed, el, ee);
        ndone = 0;
        foreach (el[j]) if (el[j]) ndone++;
        vectors++;
        if (act_data.size() - d0 != ed.size() || act_err.size() - e0 != ee.size() || done_cnt - n0 != ndone) begin
            miscompares++;
            $display("FAIL rand_counts: bytes=%0d errs=%0d done=%0d want bytes=%0d errs=%0d done=%0d",
                     act_data.size() - d0, act_err.size() - e0, done_cnt - n0, ed.size(), ee.size(), ndone);
        end
        for (int j = 0; j < ed.size() && d0 + j < act_data.size(); j++) begin
            vectors++;
            if (act_data[d0+j] !== ed[j] || act_last[d0+j] !== el[j]) begin
                miscompares++;
                $display("FAIL rand_byte%0d: got %h/%b want %h/%b", j, act_data[d0+j], act_last[d0+j], ed[j], el[j]);
            end
        end
        for (int j = 0; j < ee.size() && e0 + j < act_err.size(); j++) begin
            vectors++;
            if (act_err[e0+j] !== ee[j]) begin
                miscompares++;
                $display("FAIL rand_err%0d: got code %b want %b", j, act_err[e0+j], ee[j]);
            end
        end
        vectors++;
        if (stall_viol != 0 || both_viol != 0) begin
            miscompares++;
            $display("FAIL protocol: stall_viol=%0d err_done_overlap=%0d want 0 and 0", stall_viol, both_viol);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_bad_len();
        test_timeout();
        test_back_to_back_overrun();
        test_reset_mid_drain();
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, the maximum payload bytes per frame (range 1..255).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 5000, the maximum clk cycles allowed between bytes inside a frame.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 rx_valid  input  1  one-cycle strobe: new received byte (UART receiver ready output).
REQ-008 rx_data  input  8  received byte, qualified by rx_valid.
REQ-009 pkt_valid  output  1  payload byte available.
REQ-010 pkt_data  output  8  payload byte, qualified by pkt_valid.
REQ-011 pkt_last  output  1  high with the final payload byte of a frame.
REQ-012 pkt_ready  input  1  consumer accepts the byte when pkt_valid && pkt_ready.
REQ-013 pkt_done  output  1  one-cycle pulse when the last payload byte is accepted.
REQ-014 pkt_err  output  1  one-cycle error pulse.
REQ-015 err_code  output  2  error cause, valid with pkt_err: 00 overrun, 01 bad length, 10 checksum, 11 timeout; holds last value otherwise.

Function
REQ-016 Frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, CHK; CHK = XOR of LEN and all payload bytes.
REQ-017 FSM states SHALL be IDLE, GET_LEN, GET_PAYLOAD, GET_CHK, DRAIN.
REQ-018 IDLE: rx_valid with rx_data == SYNC_BYTE -> GET_LEN; any other byte discarded silently, stay IDLE.
REQ-019 GET_LEN: LEN in 1..MAX_LEN -> store LEN, seed running XOR with LEN, -> GET_PAYLOAD; LEN 0 or > MAX_LEN -> pkt_err, err_code 01, -> IDLE.
REQ-020 GET_PAYLOAD: each byte written to an internal MAX_LEN x 8 buffer at write index 0..LEN-1 and XORed into running checksum; after byte LEN -> GET_CHK.
REQ-021 GET_CHK: byte == running XOR -> DRAIN next cycle; mismatch -> pkt_err, err_code 10, -> IDLE, buffer discarded.
REQ-022 Store-and-forward: no payload byte SHALL appear on pkt_valid before its frame's checksum passes.
REQ-023 Latency: pkt_valid SHALL assert the cycle after the accepted CHK strobe, with buffer byte 0 on pkt_data.
REQ-024 DRAIN: pkt_data/pkt_last SHALL be stable while pkt_valid && !pkt_ready; read index advances only on handshake.
REQ-025 On handshake of byte LEN-1 (pkt_last high): pkt_done pulses that cycle, pkt_valid drops next cycle, -> IDLE.
REQ-026 rx_valid during DRAIN SHALL be discarded with pkt_err, err_code 00; drain continues unaffected.
REQ-027 Timeout counter SHALL clear on every rx_valid and on entry to GET_LEN; in GET_LEN/GET_PAYLOAD/GET_CHK, reaching TIMEOUT_CYCLES -> pkt_err, err_code 11, -> IDLE; counter inactive in IDLE and DRAIN.
REQ-028 If timeout and rx_valid coincide, rx_valid SHALL take priority (byte processed, counter cleared).
REQ-029 SYNC_BYTE value inside LEN, payload or CHK SHALL be treated as data, not as a resync.
REQ-030 pkt_err and pkt_done SHALL never assert in the same cycle except REQ-026 overrun coinciding with final handshake, where both pulse.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, pkt_valid 0, pkt_last 0, pkt_data 0, pkt_done 0, pkt_err 0, err_code 00, all indices, LEN, checksum and timeout counter 0.
REQ-032 Reset mid-frame or mid-drain SHALL abandon the frame with no pkt_done or pkt_err pulse; the first frame after release SHALL be decoded normally.

Verification
REQ-033 Good frame: A5 03 11 22 33 03, pkt_ready=1 -> pkt_data 11,22,33 on consecutive cycles starting cycle after CHK, pkt_last and pkt_done with 33, no pkt_err.
REQ-034 Bad checksum: A5 02 AA 55 00 -> pkt_err with err_code 10, pkt_valid never asserts; following A5 01 7E 7F delivers 7E with pkt_last.
REQ-035 Bad length: A5 00 and A5 11 (MAX_LEN=16) -> each pkt_err with err_code 01, FSM back in IDLE.
REQ-036 Timeout: A5 02 10 then silence -> pkt_err, err_code 11 exactly TIMEOUT_CYCLES after the 10 strobe; next good frame decodes.
REQ-037 Backpressure/overrun: good frame A5 02 A5 B6 11 (A5 in payload), pkt_ready toggled 0/1 each cycle, extra rx byte during DRAIN -> A5, B6 delivered stable under stall, pkt_err err_code 00 for extra byte.
REQ-038 Reset mid-drain: rst_n low while pkt_valid high -> all outputs 0 at once, no pkt_done; next frame A5 01 42 43 delivers 42.
